// File: rtl/switch_bounce_gen.sv
// Mechanical-switch bounce emulator: on request, drives an LFSR-driven burst of
// bounce states onto sw_o, then settles at the requested level and pulses done_o.
module switch_bounce_gen #(
    parameter int          BOUNCE_CYCLES = 2,
    parameter int          N_BOUNCES     = 20,
    parameter int          SETTLE_CYCLES = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic        RESET_LEVEL   = 1'b1
) (
    input  logic                               clk_50,
    input  logic                               reset_n,
    input  logic                               req_i,
    input  logic                               target_i,
    output logic                               sw_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [$clog2(N_BOUNCES+1)-1:0]     bounce_cnt_o
);

    localparam int CNT_W   = $clog2(N_BOUNCES + 1);
    localparam int IVL_MAX = (BOUNCE_CYCLES > SETTLE_CYCLES) ? BOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int IVL_W   = $clog2(IVL_MAX + 1);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [IVL_W-1:0] BC_LAST   = IVL_W'(BOUNCE_CYCLES - 1);
    localparam logic [IVL_W-1:0] SC_LAST   = IVL_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N_BOUNCES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      lfsr, lfsr_nxt;
    logic [IVL_W-1:0] ivl, ivl_nxt;
    logic             tgt, tgt_nxt;
    logic             sw_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ivl_end_b, ivl_end_s, cnt_full;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign ivl_end_b = (ivl == BC_LAST);
    assign ivl_end_s = (ivl == SC_LAST);
    assign cnt_full  = (bounce_cnt_o == CNT_FULL);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            lfsr         <= SEED;
            ivl          <= '0;
            tgt          <= RESET_LEVEL;
            sw_o         <= RESET_LEVEL;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            bounce_cnt_o <= '0;
        end else begin
            state        <= state_nxt;
            lfsr         <= lfsr_nxt;
            ivl          <= ivl_nxt;
            tgt          <= tgt_nxt;
            sw_o         <= sw_nxt;
            busy_o       <= busy_nxt;
            done_o       <= done_nxt;
            bounce_cnt_o <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_i) state_nxt = S_BOUNCE;
            S_BOUNCE: if (ivl_end_b && cnt_full) state_nxt = S_SETTLE;
            S_SETTLE: if (ivl_end_s) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The interval counter is shared: it paces bounce events, then the settle hold.
    always_comb begin
        lfsr_nxt = lfsr;
        ivl_nxt  = ivl;
        tgt_nxt  = tgt;
        sw_nxt   = sw_o;
        busy_nxt = busy_o;
        done_nxt = 1'b0;
        cnt_nxt  = bounce_cnt_o;
        case (state)
            S_IDLE: begin
                if (req_i) begin
                    tgt_nxt  = target_i;
                    sw_nxt   = ~target_i;
                    busy_nxt = 1'b1;
                    cnt_nxt  = '0;
                    ivl_nxt  = '0;
                end
            end
            S_BOUNCE: begin
                if (ivl_end_b) begin
                    ivl_nxt = '0;
                    if (cnt_full) begin
                        sw_nxt = tgt;
                    end else begin
                        lfsr_nxt = lfsr_step(lfsr);
                        sw_nxt   = lfsr_nxt[0];
                        cnt_nxt  = bounce_cnt_o + CNT_W'(1);
                    end
                end else begin
                    ivl_nxt = ivl + IVL_W'(1);
                end
            end
            S_SETTLE: begin
                if (ivl_end_s) begin
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end else begin
                    ivl_nxt = ivl + IVL_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
